// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the UART echo design.
// The RX, TX and echo buffer stages all use the byte width, the escape
// constants and the mode type defined here.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    localparam logic [UART_BYTE_W-1:0] ESC_PREFIX     = 8'hFF;
    localparam logic [3:0]             ESC_CMD_NIBBLE = 4'hF;

    typedef logic [3:0] uart_mode_t;

    localparam uart_mode_t MODE_RESET_DEFAULT = 4'd1;

    typedef enum logic {
        ESC_IDLE  = 1'b0,
        ESC_ARMED = 1'b1
    } esc_state_t;

    // A mode command is any byte with the command high nibble other than
    // the prefix itself, which instead re-arms the parser.
    function automatic logic is_mode_cmd(input logic [UART_BYTE_W-1:0] b);
        return (b[7:4] == ESC_CMD_NIBBLE) && (b != ESC_PREFIX);
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: first-word-fall-through byte FIFO with sticky overflow.
//   clk, rst_n       clock, async active-low reset
//   wr_en, wr_data   write strobe and data (no backpressure; dropped when full)
//   rd_data          head entry, valid while rd_valid=1
//   rd_valid         FIFO not empty
//   rd_ready         consumer accepts the head entry this cycle
//   level            number of stored entries, 0..DEPTH
//   empty, full      decoded from level
//   overflow         sticky, set when a write is dropped
//   ovf_clr          synchronous clear of overflow (a same-cycle drop wins)
module uart_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    output logic [W-1:0]  rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [LW-1:0] level,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    input  logic          ovf_clr
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          drop;

    assign empty    = (level == '0);
    assign full     = (level == LW'(DEPTH));
    assign rd_valid = !empty;
    assign rd_data  = mem[rd_ptr];

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign pop  = rd_valid && rd_ready;
    assign push = wr_en && (!full || pop);
    assign drop = wr_en && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_echo_buffer.sv
// uart_echo_buffer: buffers received bytes for echo and snoops the RX stream
// for the mode escape (0xFF followed by 0xFn), driving the shared UART mode.
//   clk, rst_n          clock, async active-low reset
//   rx_data, rx_valid   received byte and its one-cycle strobe
//   tx_data, tx_valid   head byte offered to TX
//   tx_ready            TX accepts the head byte
//   mode                current UART mode to RX and TX
//   armed               escape prefix seen, waiting for the mode byte
//   level, empty, full  FIFO occupancy
//   overflow, ovf_clr   sticky drop flag and its clear
//
// Escape parser states:
//   state     | meaning
//   ESC_IDLE  | no prefix pending
//   ESC_ARMED | 0xFF seen; next byte decides whether mode changes
module uart_echo_buffer
    import uart_pkg::*;
#(
    parameter int         DEPTH      = 16,
    parameter uart_mode_t MODE_RESET = MODE_RESET_DEFAULT,
    localparam int        LW         = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [UART_BYTE_W-1:0] rx_data,
    input  logic                   rx_valid,
    output logic [UART_BYTE_W-1:0] tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output uart_mode_t             mode,
    output logic                   armed,
    output logic [LW-1:0]          level,
    output logic                   empty,
    output logic                   full,
    output logic                   overflow,
    input  logic                   ovf_clr
);

    esc_state_t state;
    esc_state_t state_nxt;
    logic       mode_load;

    // Every byte is echoed, escape bytes included.
    uart_byte_fifo #(
        .DEPTH (DEPTH),
        .W     (UART_BYTE_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (rx_valid),
        .wr_data  (rx_data),
        .rd_data  (tx_data),
        .rd_valid (tx_valid),
        .rd_ready (tx_ready),
        .level    (level),
        .empty    (empty),
        .full     (full),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ESC_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The parser sees every strobe, even ones the FIFO drops. A repeated
    // prefix keeps the parser armed.
    always_comb begin
        state_nxt = state;
        if (rx_valid) begin
            if (rx_data == ESC_PREFIX) begin
                state_nxt = ESC_ARMED;
            end else begin
                state_nxt = ESC_IDLE;
            end
        end
    end

    always_comb begin
        armed     = (state == ESC_ARMED);
        mode_load = rx_valid && (state == ESC_ARMED) && is_mode_cmd(rx_data);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode <= MODE_RESET;
        end else if (mode_load) begin
            mode <= rx_data[3:0];
        end
    end

endmodule

// File: tb/tb_uart_echo_buffer.sv
// tb_uart_echo_buffer: directed self-checking bench for uart_echo_buffer.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_echo_buffer;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [3:0]    mode;
    logic          armed;
    logic [LW-1:0] level;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          ovf_clr;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    uart_echo_buffer #(.DEPTH(DEPTH), .MODE_RESET(4'd1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .mode     (mode),
        .armed    (armed),
        .level    (level),
        .empty    (empty),
        .full     (full),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        tx_ready = 1'b1;
        while (!empty && n < 64) begin
            @(negedge clk);
            n++;
        end
        tx_ready = 1'b0;
        check("drain_empty", {31'd0, empty}, 32'd1);
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        ovf_clr  = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_level",    32'(level),    32'd0);
        check("rst_empty",    32'(empty),    32'd1);
        check("rst_full",     32'(full),     32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_armed",    32'(armed),    32'd0);
        check("rst_mode",     32'(mode),     32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic FWFT ordering
        push(8'h41);
        check("first_tx_valid", 32'(tx_valid), 32'd1);
        check("first_tx_data",  32'(tx_data),  32'h41);
        push(8'h42);
        push(8'h43);
        check("abc_level",   32'(level),   32'd3);
        check("abc_head",    32'(tx_data), 32'h41);
        check("abc_valid",   32'(tx_valid), 32'd1);
        tx_ready = 1'b1;
        check("pop0", 32'(tx_data), 32'h41);
        @(negedge clk);
        check("pop1", 32'(tx_data), 32'h42);
        @(negedge clk);
        check("pop2", 32'(tx_data), 32'h43);
        @(negedge clk);
        tx_ready = 1'b0;
        check("abc_empty",    32'(empty),    32'd1);
        check("abc_tx_valid", 32'(tx_valid), 32'd0);

        // Overflow: 17 bytes into 16 slots
        for (int i = 0; i < 17; i++) push(8'(i));
        check("ovf_level",    32'(level),    32'd16);
        check("ovf_full",     32'(full),     32'd1);
        check("ovf_overflow", 32'(overflow), 32'd1);
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("ovf_drain", 32'(tx_data), 32'(i));
            @(negedge clk);
        end
        tx_ready = 1'b0;
        check("ovf_drained_empty", 32'(empty), 32'd1);

        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Full FIFO with simultaneous write and pop
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        tx_ready = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        check("fullrw_level",    32'(level),    32'd16);
        check("fullrw_overflow", 32'(overflow), 32'd0);
        check("fullrw_head",     32'(tx_data),  32'h21);
        tx_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            check("fullrw_drain", 32'(tx_data), 32'h21 + 32'(i));
            @(negedge clk);
        end
        check("fullrw_last", 32'(tx_data), 32'h55);
        @(negedge clk);
        tx_ready = 1'b0;
        check("fullrw_empty", 32'(empty), 32'd1);

        // Escape parser
        push(8'hFF);
        check("esc_armed", 32'(armed), 32'd1);
        check("esc_mode_hold", 32'(mode), 32'd1);
        push(8'hF4);
        check("esc_mode4",   32'(mode),  32'd4);
        check("esc_disarm",  32'(armed), 32'd0);
        check("esc_level2",  32'(level), 32'd2);
        tx_ready = 1'b1;
        check("esc_echo_ff", 32'(tx_data), 32'hFF);
        @(negedge clk);
        check("esc_echo_f4", 32'(tx_data), 32'hF4);
        @(negedge clk);
        tx_ready = 1'b0;
        push(8'hFF);
        push(8'h12);
        check("esc_bad_mode",  32'(mode),  32'd4);
        check("esc_bad_armed", 32'(armed), 32'd0);
        push(8'hFF);
        push(8'hFF);
        check("esc_rearm", 32'(armed), 32'd1);
        check("esc_rearm_mode", 32'(mode), 32'd4);
        push(8'hF7);
        check("esc_mode7", 32'(mode), 32'd7);
        push(8'hF2);
        check("esc_unarmed_f2", 32'(mode), 32'd7);
        drain();

        // Drop coincident with ovf_clr: set wins
        for (int i = 0; i < 17; i++) push(8'h60 + 8'(i));
        check("ovf2_set", 32'(overflow), 32'd1);
        rx_valid = 1'b1;
        rx_data  = 8'h99;
        ovf_clr  = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check("ovf2_set_wins", 32'(overflow), 32'd1);
        check("ovf2_level",    32'(level),    32'd16);
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf2_cleared", 32'(overflow), 32'd0);
        drain();

        // Asynchronous reset mid-stream
        push(8'h01);
        push(8'h02);
        push(8'h03);
        push(8'h04);
        push(8'hFF);
        check("pre_rst_level", 32'(level), 32'd5);
        check("pre_rst_armed", 32'(armed), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_level",    32'(level),    32'd0);
        check("arst_tx_valid", 32'(tx_valid), 32'd0);
        check("arst_armed",    32'(armed),    32'd0);
        check("arst_mode",     32'(mode),     32'd1);
        check("arst_empty",    32'(empty),    32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push(8'hF5);
        check("post_rst_mode", 32'(mode), 32'd1);
        check("post_rst_head", 32'(tx_data), 32'hF5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_echo_buffer.md
Name: uart_echo_buffer

Overview:
- Byte buffer and command snooper between the UART RX and TX stages of the echo design.
- Accepts single-cycle received-byte strobes and stores them in a FIFO. Presents them to TX via a valid/ready handshake, so back-to-back RX bytes are not lost while TX is busy.
- Watches the RX stream for the mode-escape sequence (0xFF, then 0xFn) and drives the shared 4-bit UART mode to both RX and TX.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 2.
- MODE_RESET, 4'd1, mode value after reset.
- LW (localparam), $clog2(DEPTH)+1, width of level.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe from RX; no backpressure possible.
- tx_data  out  8  byte offered to TX (head of FIFO).
- tx_valid  out  1  head byte available.
- tx_ready  in  1  TX can accept a byte.
- mode  out  4  current UART mode to RX and TX.
- armed  out  1  escape prefix 0xFF seen; waiting for mode byte.
- level  out  LW  number of stored bytes, 0..DEPTH.
- empty  out  1  level==0.
- full  out  1  level==DEPTH.
- overflow  out  1  sticky: at least one byte dropped.
- ovf_clr  in  1  synchronous clear of overflow.

Behaviour:
- Reset (async assert, sync-safe deassert by system):
  - level=0, empty=1, full=0, tx_valid=0.
  - overflow=0, armed=0, mode=MODE_RESET.
  - Pointers=0; memory contents not reset.
  - Reset mid-operation discards all stored bytes and any pending escape.
- FIFO is first-word-fall-through:
  - tx_data=mem[rd_ptr]; tx_valid=!empty; both driven from registered state only.
  - Write: rx_valid=1 and (!full or pop this cycle). Stores at wr_ptr; wr_ptr++ mod DEPTH.
  - Pop: tx_valid && tx_ready. rd_ptr++ mod DEPTH.
  - tx_data must be stable while tx_valid=1 and tx_ready=0.
  - Latency: byte written at edge N appears on tx_data/tx_valid after edge N (visible in cycle N+1).
  - Empty + rx_valid: tx_valid rises next cycle. No same-cycle bypass.
- Level update:
  - Write only: +1.
  - Pop only: -1.
  - Both: unchanged.
  - Full + pop + write: write accepted, level stays DEPTH.
  - Empty: pop impossible, since tx_valid=0.
- Overflow:
  - rx_valid while full with no pop: byte dropped and overflow<=1.
  - ovf_clr clears overflow. If a drop occurs in the same cycle, set wins.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. full/empty are derived from level, not from pointer compare.
- Escape parser: evaluates every rx_valid byte, independent of FIFO full/drop. All bytes, escape bytes included, are still buffered for echo.
  - Any state, byte==8'hFF: armed<=1.
  - armed=1, byte[7:4]==4'hF, byte!=8'hFF: mode<=byte[3:0], armed<=0.
  - armed=1, any other byte: armed<=0, mode unchanged.
  - armed=0, non-0xFF byte: no change.
  - 0xFF,0xFF,0xF3 sequence: armed remains 1 through the second 0xFF, then mode=3.
  - mode changes on the edge after the qualifying byte's strobe.
- Arithmetic: all counters unsigned; no saturation beyond the rules above.

Decomposition:
- Shared package uart_pkg:
  - UART_BYTE_W=8.
  - ESC_PREFIX=8'hFF.
  - ESC_CMD_NIBBLE=4'hF.
  - typedef logic [3:0] uart_mode_t.
  - MODE_RESET default constant; RX and TX use the same type and constants.
- One natural sub-module: uart_byte_fifo.
  - Parameters: DEPTH and width.
  - Contents: FWFT storage, pointers, level, full/empty, overflow.
  - uart_echo_buffer instantiates it and adds the escape parser and mode register.

Test Plan:
- Reset, then 3 strobes 0x41,0x42,0x43 with tx_ready=0 -> level=3, tx_data=0x41, tx_valid=1. Raise tx_ready -> 0x41,0x42,0x43 popped on 3 consecutive edges, then empty=1, tx_valid=0.
- 17 strobes 0x00..0x10 with tx_ready=0, DEPTH=16 -> level=16, full=1, overflow=1. Drain yields 0x00..0x0F; 0x10 is absent.
- Full FIFO, rx_valid and tx_ready in the same cycle -> level stays 16, overflow stays 0. New byte is the last one out.
- Bytes 0xFF,0xF4 -> mode=4 and armed=0 after the second strobe; both bytes echoed. Bytes 0xFF,0x12 -> mode unchanged (4), armed=0. Bytes 0xFF,0xFF,0xF7 -> mode=7.
- Overflow set, then ovf_clr pulse coincident with another dropped byte -> overflow stays 1. Next ovf_clr alone -> 0.
- Assert rst_n=0 mid-stream with level=5 and armed=1 -> level=0, tx_valid=0, armed=0, mode=1 immediately, asynchronously.
